// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Packet-locked round-robin arbiter sharing one uart_tx transmitter among
// NUM_REQ byte-stream requesters. A winner keeps the grant until it sends a
// byte flagged req_last, or until MAX_BURST bytes have gone out in the
// current grant. Every byte goes through the uart_tx en/busy handshake:
// accept -> one-cycle send strobe -> wait for busy to rise -> wait for busy
// to fall.
//
// Parameters:
//   NUM_REQ     number of requesters (2..8)
//   MAX_BURST   bytes per grant before a forced release (>= 1)
//
// Ports:
//   clk            in   system clock
//   resetn         in   synchronous active-low reset
//   req_valid      in   [NUM_REQ]    requester i presents a byte
//   req_data       in   [8*NUM_REQ]  requester i byte at [8i+7:8i]
//   req_last       in   [NUM_REQ]    byte is the final byte of its packet
//   req_ready      out  [NUM_REQ]    byte accepted this cycle (combinational)
//   grant          out  [NUM_REQ]    one-hot current owner, zero when none
//   uart_tx_en     out  one-cycle registered send strobe to uart_tx
//   uart_tx_data   out  [8]  registered byte to uart_tx
//   uart_tx_busy   in   busy flag from uart_tx
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned MAX_BURST = 16
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [8*NUM_REQ-1:0]   req_data,
   input  logic [NUM_REQ-1:0]     req_last,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [NUM_REQ-1:0]     grant,
   output logic                   uart_tx_en,
   output logic [7:0]             uart_tx_data,
   input  logic                   uart_tx_busy
);

   localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned BW = $clog2(MAX_BURST + 1);
   localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
   localparam logic [IW-1:0] OWNER_INIT = IW'(NUM_REQ - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_OWN,
      ST_ISSUE,
      ST_WAIT_BUSY,
      ST_WAIT_DONE
   } state_t;

   state_t               r_state;
   logic [NUM_REQ-1:0]   r_grant;
   logic [IW-1:0]        r_owner;
   logic [IW-1:0]        r_last_owner;
   logic [BW-1:0]        r_burst;
   logic                 r_cap_last;
   logic                 r_tx_en;
   logic [7:0]           r_tx_data;

   logic                 w_any_valid;
   logic [IW-1:0]        w_win_idx;
   logic [NUM_REQ-1:0]   w_win_onehot;
   logic                 w_own_valid;
   logic                 w_own_last;
   logic [7:0]           w_own_data;
   logic                 w_accept_window;
   logic                 w_handshake;
   logic                 w_release;

   // Round-robin pick: offsets are scanned from the farthest down to the
   // nearest so the nearest valid requester after last_owner overwrites all
   // others and wins.
   always_comb begin
      int unsigned v_idx;
      w_any_valid  = |req_valid;
      w_win_idx    = '0;
      w_win_onehot = '0;
      v_idx        = 0;
      for (int unsigned k = NUM_REQ; k >= 1; k--) begin
         v_idx = (32'(r_last_owner) + k) % NUM_REQ;
         if (req_valid[IW'(v_idx)]) begin
            w_win_idx                   = IW'(v_idx);
            w_win_onehot                = '0;
            w_win_onehot[IW'(v_idx)]    = 1'b1;
         end
      end
   end

   // Owner's byte/last selected by the one-hot grant; non-owner slices
   // never reach the capture registers.
   always_comb begin
      w_own_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (r_grant[i]) begin
            w_own_data = req_data[8*i +: 8];
         end
      end
   end

   assign w_own_valid     = |(req_valid & r_grant);
   assign w_own_last      = |(req_last & r_grant);
   assign w_accept_window = (r_state == ST_OWN) && !uart_tx_busy;
   assign w_handshake     = w_accept_window && w_own_valid;
   assign w_release       = r_cap_last || (r_burst == BURST_MAX);

   // Only the owner's bit can be set because the grant is one-hot.
   assign req_ready    = w_accept_window ? (req_valid & r_grant) : '0;
   assign grant        = r_grant;
   assign uart_tx_en   = r_tx_en;
   assign uart_tx_data = r_tx_data;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state      <= ST_IDLE;
         r_grant      <= '0;
         r_owner      <= '0;
         r_last_owner <= OWNER_INIT;
         r_burst      <= '0;
         r_cap_last   <= 1'b0;
         r_tx_en      <= 1'b0;
         r_tx_data    <= '0;
      end else begin
         r_tx_en <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_any_valid) begin
                  r_grant <= w_win_onehot;
                  r_owner <= w_win_idx;
                  r_state <= ST_OWN;
               end
            end
            ST_OWN: begin
               // The owner dropping valid simply holds the grant here.
               if (w_handshake) begin
                  r_tx_data  <= w_own_data;
                  r_cap_last <= w_own_last;
                  r_burst    <= r_burst + BW'(1);
                  r_tx_en    <= 1'b1;
                  r_state    <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               r_state <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
               if (uart_tx_busy) begin
                  r_state <= ST_WAIT_DONE;
               end
            end
            ST_WAIT_DONE: begin
               if (!uart_tx_busy) begin
                  if (w_release) begin
                     r_grant      <= '0;
                     r_last_owner <= r_owner;
                     r_burst      <= '0;
                     r_cap_last   <= 1'b0;
                     r_state      <= ST_IDLE;
                  end else begin
                     r_state <= ST_OWN;
                  end
               end
            end
            default: begin
               r_grant <= '0;
               r_burst <= '0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

   localparam int N     = 4;
   localparam int MAX_B = 4;

   typedef struct packed { logic [7:0] d; logic l; } byte_t;
   typedef struct packed { logic [3:0] g; logic [7:0] d; } tx_t;
   typedef struct { int prev; logic [3:0] mask; logic [3:0] exp_grant; } rr_vec_t;

   logic           clk = 1'b0;
   logic           resetn;
   logic [N-1:0]   req_valid;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   grant;
   logic           uart_tx_en;
   logic [7:0]     uart_tx_data;
   logic           uart_tx_busy;

   uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MAX_B)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .grant        (grant),
      .uart_tx_en   (uart_tx_en),
      .uart_tx_data (uart_tx_data),
      .uart_tx_busy (uart_tx_busy)
   );

   always #5 clk = ~clk;

   int      n_pass  = 0;
   int      n_total = 0;
   byte_t   rq[N][$];
   byte_t   mq[N][$];
   tx_t     tx_log[$];
   tx_t     exp_q[$];
   logic [N-1:0] stall = '0;
   bit      rand_timing = 1'b0;
   int      en_cnt = 0;
   int      rdy_cnt[N];
   logic    prev_en = 1'b0;
   rr_vec_t rr_tab[9];

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_total++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp_v, $time);
   endfunction

   task automatic cyc();
      @(negedge clk);
      #2;
   endtask

   task automatic push(input int r, input logic [7:0] d, input logic l);
      rq[r].push_back({d, l});
   endtask

   task automatic wait_log(input int n, input int budget, input string nm);
      int b = budget;
      while (tx_log.size() < n && b > 0) begin cyc(); b--; end
      chk(nm, 32'(tx_log.size() >= n), 32'd1);
   endtask

   task automatic wait_grant(input logic nz, input int budget, input string nm);
      int b = budget;
      while (((grant != '0) != nz) && b > 0) begin cyc(); b--; end
      chk(nm, 32'((grant != '0) == nz), 32'd1);
   endtask

   task automatic chk_tx(input string nm, input int idx, input int r, input logic [7:0] d);
      tx_t e;
      e = (idx < tx_log.size()) ? tx_log[idx] : tx_t'(0);
      chk({nm, "_grant"}, 32'(e.g), 32'(4'b0001 << r));
      chk({nm, "_data"},  32'(e.d), 32'(d));
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      for (int i = 0; i < N; i++) rq[i].delete();
      stall = '0;
      repeat (3) cyc();
      resetn = 1'b1;
      cyc();
   endtask

   // Transmitter model: busy rises one cycle after the strobe cycle (plus an
   // optional random lag) and stays high for one frame.
   initial begin : uart_model
      int lag, frm;
      uart_tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (uart_tx_en) begin
            lag = rand_timing ? int'($urandom_range(1, 3)) : 1;
            frm = rand_timing ? int'($urandom_range(1, 5)) : 4;
            repeat (lag) @(posedge clk);
            #1 uart_tx_busy = 1'b1;
            repeat (frm) @(posedge clk);
            #1 uart_tx_busy = 1'b0;
         end
      end
   end

   // Requesters: each presents the head of its queue; the head is popped
   // after an edge on which req_ready was high.
   initial begin : driver
      logic [N-1:0] acc;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      forever begin
         @(negedge clk);
         acc = resetn ? req_ready : '0;
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            if (rq[i].size() > 0 && !stall[i]) begin
               req_valid[i]       = 1'b1;
               req_data[8*i +: 8] = rq[i][0].d;
               req_last[i]        = rq[i][0].l;
            end else begin
               req_valid[i]       = 1'b0;
               req_data[8*i +: 8] = 8'($urandom);
               req_last[i]        = 1'($urandom);
            end
         end
      end
   end

   // Monitor: logs every send strobe with the grant in force, checks
   // strobe width and req_ready shape.
   initial begin : monitor
      for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
      forever begin
         @(negedge clk);
         if (uart_tx_en) begin
            tx_log.push_back({grant, uart_tx_data});
            en_cnt++;
            chk("en_single_cycle", 32'(prev_en), 32'd0);
         end
         prev_en = uart_tx_en;
         if (req_ready != '0)
            chk("ready_onehot_owner", 32'($onehot(req_ready) && ((req_ready & ~grant) == '0)), 32'd1);
         for (int i = 0; i < N; i++) rdy_cnt[i] += int'(req_ready[i]);
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", n_pass, n_total + 1);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int base, en0, rd0, b, last, w, n;
      bit stall_ok;
      byte_t cur;

      rr_tab[0] = '{-1, 4'b1111, 4'b0001};
      rr_tab[1] = '{-1, 4'b0100, 4'b0100};
      rr_tab[2] = '{-1, 4'b1010, 4'b0010};
      rr_tab[3] = '{ 0, 4'b0001, 4'b0001};
      rr_tab[4] = '{ 0, 4'b1101, 4'b0100};
      rr_tab[5] = '{ 1, 4'b1011, 4'b1000};
      rr_tab[6] = '{ 3, 4'b1110, 4'b0010};
      rr_tab[7] = '{ 2, 4'b0011, 4'b0001};
      rr_tab[8] = '{ 3, 4'b1000, 4'b1000};

      // Reset state
      resetn = 1'b0;
      repeat (3) cyc();
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_en",    32'(uart_tx_en), 32'd0);
      chk("rst_data",  32'(uart_tx_data), 32'd0);
      resetn = 1'b1;
      cyc();

      // Round-robin table: optional prior owner, then a valid mask
      for (int t = 0; t < 9; t++) begin
         do_reset();
         if (rr_tab[t].prev >= 0) begin
            base = tx_log.size();
            push(rr_tab[t].prev, 8'(8'h50 + rr_tab[t].prev), 1'b1);
            wait_log(base + 1, 60, $sformatf("rr%0d_prev_tx", t));
            wait_grant(1'b0, 60, $sformatf("rr%0d_prev_rel", t));
         end
         for (int i = 0; i < N; i++)
            if (rr_tab[t].mask[i]) push(i, 8'(8'h60 + i), 1'b1);
         wait_grant(1'b1, 20, $sformatf("rr%0d_wait", t));
         chk($sformatf("rr%0d_grant", t), 32'(grant), 32'(rr_tab[t].exp_grant));
      end

      // Single byte from requester 2
      do_reset();
      en0 = en_cnt; rd0 = rdy_cnt[2]; base = tx_log.size();
      push(2, 8'hA5, 1'b1);
      cyc();
      chk("sb_grant_before", 32'(grant), 32'd0);
      cyc();
      chk("sb_grant_next", 32'(grant), 32'b0100);
      wait_log(base + 1, 60, "sb_tx_seen");
      wait_grant(1'b0, 60, "sb_release");
      chk("sb_en_pulses", 32'(en_cnt - en0), 32'd1);
      chk("sb_ready_pulses", 32'(rdy_cnt[2] - rd0), 32'd1);
      chk_tx("sb_byte", base, 2, 8'hA5);
      chk("sb_data_hold", 32'(uart_tx_data), 32'hA5);
      chk("sb_busy_low", 32'(uart_tx_busy), 32'd0);

      // Packet lock: requester 0 sends 3 bytes while 1 waits
      do_reset();
      base = tx_log.size();
      push(1, 8'h77, 1'b1);
      push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b0); push(0, 8'h33, 1'b1);
      wait_log(base + 4, 150, "lock_count");
      chk_tx("lock0", base + 0, 0, 8'h11);
      chk_tx("lock1", base + 1, 0, 8'h22);
      chk_tx("lock2", base + 2, 0, 8'h33);
      chk_tx("lock3", base + 3, 1, 8'h77);

      // Fairness: all four with one-byte packets, two rounds
      do_reset();
      base = tx_log.size();
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < N; i++) push(i, 8'(8'h40 + 16*r + i), 1'b1);
      wait_log(base + 8, 300, "rr_fair_count");
      for (int k = 0; k < 8; k++)
         chk_tx($sformatf("rr_fair%0d", k), base + k, k % N, 8'(8'h40 + 16*(k/N) + (k%N)));

      // Burst limit: requester 1 streams 10 bytes, requester 3 has a packet
      do_reset();
      base = tx_log.size();
      for (int k = 0; k < 10; k++) push(1, 8'(8'h80 + k), 1'b0);
      push(3, 8'hC0, 1'b0); push(3, 8'hC1, 1'b1);
      wait_log(base + 12, 400, "burst_count");
      for (int k = 0; k < 4; k++) chk_tx($sformatf("burst_a%0d", k), base + k, 1, 8'(8'h80 + k));
      chk_tx("burst_b0", base + 4, 3, 8'hC0);
      chk_tx("burst_b1", base + 5, 3, 8'hC1);
      for (int k = 0; k < 6; k++) chk_tx($sformatf("burst_c%0d", k), base + 6 + k, 1, 8'(8'h84 + k));
      repeat (20) cyc();
      chk("burst_lock_held", 32'(grant), 32'b0010);

      // Owner stall mid-packet
      do_reset();
      base = tx_log.size();
      push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b0); push(0, 8'h03, 1'b1);
      push(2, 8'h20, 1'b1);
      wait_log(base + 1, 60, "stall_first");
      stall[0] = 1'b1;
      en0 = en_cnt;
      stall_ok = 1'b1;
      repeat (50) begin
         cyc();
         if (grant != 4'b0001) stall_ok = 1'b0;
      end
      chk("stall_grant_held", 32'(stall_ok), 32'd1);
      chk("stall_no_en", 32'(en_cnt - en0), 32'd0);
      stall[0] = 1'b0;
      wait_log(base + 4, 150, "stall_resume");
      chk_tx("stall0", base + 1, 0, 8'h02);
      chk_tx("stall1", base + 2, 0, 8'h03);
      chk_tx("stall2", base + 3, 2, 8'h20);

      // Reset during WAIT_DONE
      do_reset();
      base = tx_log.size();
      push(0, 8'hD0, 1'b0); push(0, 8'hD1, 1'b0); push(0, 8'hD2, 1'b1);
      push(1, 8'hE0, 1'b1);
      wait_log(base + 1, 60, "mid_first");
      b = 20;
      while (!uart_tx_busy && b > 0) begin cyc(); b--; end
      cyc();
      resetn = 1'b0;
      cyc();
      chk("mid_rst_grant", 32'(grant), 32'd0);
      chk("mid_rst_en",    32'(uart_tx_en), 32'd0);
      chk("mid_rst_data",  32'(uart_tx_data), 32'd0);
      for (int i = 0; i < N; i++) rq[i].delete();
      en0 = en_cnt;
      repeat (3) cyc();
      chk("mid_rst_no_strobe", 32'(en_cnt - en0), 32'd0);
      resetn = 1'b1;
      cyc();
      base = tx_log.size();
      for (int i = 0; i < N; i++) push(i, 8'(8'hF0 + i), 1'b1);
      wait_grant(1'b1, 20, "mid_regrant");
      chk("mid_first_winner", 32'(grant), 32'b0001);
      wait_log(base + 1, 60, "mid_after_tx");
      chk_tx("mid_after", base, 0, 8'hF0);

      // Randomized packets against a packet-level round-robin model
      rand_timing = 1'b1;
      for (int round = 0; round < 3; round++) begin
         do_reset();
         base = tx_log.size();
         exp_q.delete();
         for (int i = 0; i < N; i++) begin
            int npk, len;
            mq[i].delete();
            npk = int'($urandom_range(0, 3));
            if (i == round % N && npk == 0) npk = 1;
            for (int p = 0; p < npk; p++) begin
               len = int'($urandom_range(1, 6));
               for (int k = 0; k < len; k++) begin
                  cur = {8'($urandom), (k == len - 1)};
                  rq[i].push_back(cur);
                  mq[i].push_back(cur);
               end
            end
         end
         last = N - 1;
         forever begin
            w = -1;
            for (int k = 1; k <= N; k++) begin
               int j;
               j = (last + k) % N;
               if (w < 0 && mq[j].size() > 0) w = j;
            end
            if (w < 0) break;
            n = 0;
            do begin
               cur = mq[w].pop_front();
               exp_q.push_back({4'(4'b0001 << w), cur.d});
               n++;
            end while (!cur.l && n < MAX_B && mq[w].size() > 0);
            last = w;
         end
         wait_log(base + exp_q.size(), 40 * exp_q.size() + 100, $sformatf("rnd%0d_count", round));
         for (int k = 0; k < exp_q.size(); k++) begin
            tx_t e;
            e = (base + k < tx_log.size()) ? tx_log[base + k] : tx_t'(0);
            chk($sformatf("rnd%0d_tx%0d", round, k), 32'(e), 32'(exp_q[k]));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
